// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response, decode handshake.
// if_misalign exists only when PC_FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_inst,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    output if_misalign,
`endif
    input  if_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_inst,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    input  if_misalign,
`endif
    output if_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// PC fetch: one outstanding imem request, 3 cycles/instruction at 1-cycle memory latency; HOLD stalls on if_ready=0.
// Redirect wins every cycle; PC_FETCH_MISALIGN_TRAP_EN adds a TRAP state for misaligned redirect targets.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.master bus
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] rpc;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic pending_q, pending_d;
  logic redir_bad;
  logic outst;

  assign rpc       = bus.redirect_pc;
  assign redir_bad = bus.redirect_valid & (|bus.redirect_pc[1:0]);
  // A request is still in flight after this cycle; a response must be swallowed later.
  assign outst = ((state_q == S_REQ)  &&  bus.imem_gnt)    ||
                 ((state_q == S_WAIT) && !bus.imem_rvalid) ||
                 ((state_q == S_DROP) && !bus.imem_rvalid) ||
                 ((state_q == S_TRAP) && pending_q && !bus.imem_rvalid);
`else
  assign rpc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    pending_d  = outst;
`endif
    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = rpc;
          state_d    = bus.imem_gnt ? S_DROP : S_REQ;
        end else if (bus.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = rpc;
          state_d    = bus.imem_rvalid ? S_REQ : S_DROP;
        end else if (bus.imem_rvalid) begin
          if_inst_d = bus.imem_rdata;
          if_pc_d   = fetch_pc_q;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = rpc;
          state_d    = S_REQ;
        end else if (bus.if_ready) begin
          fetch_pc_d = if_pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        // A redirect here only retargets; the stale response must still be consumed.
        if (bus.redirect_valid) fetch_pc_d = rpc;
        if (bus.imem_rvalid) state_d = S_REQ;
      end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      S_TRAP: begin
        if (bus.redirect_valid) begin
          misalign_d = 1'b0;
          fetch_pc_d = rpc;
          state_d    = outst ? S_DROP : S_REQ;
        end
      end
`endif
      default: state_d = S_REQ;
    endcase
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    if (redir_bad) begin
      state_d    = S_TRAP;
      fetch_pc_d = fetch_pc_q;
      misalign_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0013;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
      pending_q  <= pending_d;
`endif
    end
  end

  // Gated by rst_n so nothing is requested or presented while reset is held.
  assign bus.imem_req  = rst_n && (state_q == S_REQ);
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = rst_n && (state_q == S_HOLD);
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign bus.if_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; covers sequential fetch, stall, redirects, wrap and misaligned redirect.
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1ns after the edge for sampling.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic rdr, input logic [31:0] rpc);
    bus.imem_gnt       = g;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rd;
    bus.if_ready       = rdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Fetch one word at the current REQ address and check it on the decode side.
  task automatic fetch_one(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check_eq({tag, "_req"},  {31'd0, bus.imem_req}, 32'd1);
    check_eq({tag, "_addr"}, bus.imem_addr, pc);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq({tag, "_wait_req"}, {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, inst, 1'b0, 1'b0, 32'h0);
    check_eq({tag, "_vld"},  {31'd0, bus.if_valid}, 32'd1);
    check_eq({tag, "_pc"},   bus.if_pc, pc);
    check_eq({tag, "_inst"}, bus.if_inst, inst);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    check_eq("rst_req",  {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_vld",  {31'd0, bus.if_valid}, 32'd0);
    check_eq("rst_pc",   bus.if_pc, 32'h0000_0000);
    check_eq("rst_inst", bus.if_inst, 32'h0000_0013);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_req",  {31'd0, bus.imem_req}, 32'd1);
    check_eq("post_rst_addr", bus.imem_addr, 32'h0000_0000);

    // Three back-to-back fetches, each exactly 3 cycles apart.
    fetch_one("seq0", 32'h0000_0000, 32'h1000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    fetch_one("seq1", 32'h0000_0004, 32'h1000_0004);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    fetch_one("seq2", 32'h0000_0008, 32'h1000_0008);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Decode stall for 5 cycles.
    fetch_one("stall", 32'h0000_000C, 32'hCAFE_0013);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_eq("stall_vld",  {31'd0, bus.if_valid}, 32'd1);
      check_eq("stall_pc",   bus.if_pc, 32'h0000_000C);
      check_eq("stall_inst", bus.if_inst, 32'hCAFE_0013);
      check_eq("stall_req",  {31'd0, bus.imem_req}, 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("stall_acc_vld",  {31'd0, bus.if_valid}, 32'd0);
    check_eq("stall_acc_addr", bus.imem_addr, 32'h0000_0010);

    // Redirect while waiting for data: stale response dropped.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    check_eq("drop_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("drop_vld", {31'd0, bus.if_valid}, 32'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    check_eq("drop_done_vld", {31'd0, bus.if_valid}, 32'd0);
    fetch_one("redir100", 32'h0000_0100, 32'h1000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with rvalid and if_ready.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h0000_0200);
    check_eq("rv_redir_vld", {31'd0, bus.if_valid}, 32'd0);
    fetch_one("redir200", 32'h0000_0200, 32'h1000_0200);

    // Redirect in HOLD overrides acceptance.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    check_eq("hold_redir_vld",  {31'd0, bus.if_valid}, 32'd0);
    check_eq("hold_redir_addr", bus.imem_addr, 32'h0000_0300);

    // Redirect in REQ without grant, then with grant.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0400);
    check_eq("req_redir_addr", bus.imem_addr, 32'h0000_0400);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0500);
    check_eq("req_gnt_redir_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    check_eq("req_gnt_redir_vld",  {31'd0, bus.if_valid}, 32'd0);
    check_eq("req_gnt_redir_addr", bus.imem_addr, 32'h0000_0500);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_one("wrap", 32'hFFFF_FFFC, 32'h1234_5678);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Misaligned redirect target.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    check_eq("trap_flag", {31'd0, bus.if_misalign}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("trap_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("trap_vld", {31'd0, bus.if_valid}, 32'd0);
      idle();
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    check_eq("trap_clr",  {31'd0, bus.if_misalign}, 32'd0);
    check_eq("trap_req2", {31'd0, bus.imem_req}, 32'd1);
    check_eq("trap_addr", bus.imem_addr, 32'h0000_0300);
`else
    check_eq("misalign_req",  {31'd0, bus.imem_req}, 32'd1);
    check_eq("misalign_addr", bus.imem_addr, 32'h0000_0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port redirect_valid, input, 1 bit: the execute stage requests a non-sequential next PC.
REQ-005 The block SHALL have port redirect_pc, input, 32 bits: the redirect target, sampled when redirect_valid=1.
REQ-006 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: fetch address, word-aligned.
REQ-008 The block SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-009 The block SHALL have port imem_rvalid, input, 1 bit: read data valid, exactly one per grant, at least 1 cycle after the grant.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-011 The block SHALL have port if_valid, output, 1 bit: instruction presented to decode.
REQ-012 The block SHALL have port if_ready, input, 1 bit: decode accepts (low = stall).
REQ-013 The block SHALL have ports if_pc (output, 32 bits: PC of the presented instruction) and if_inst (output, 32 bits: the presented instruction).

Function
REQ-014 The FSM SHALL have states REQ (request pending), WAIT (granted, awaiting data), HOLD (instruction presented, not accepted), DROP (awaiting a stale response to discard).
REQ-015 In REQ: imem_req=1; imem_addr=fetch_pc, held stable until imem_gnt; on imem_gnt -> WAIT.
REQ-016 In WAIT, on imem_rvalid the block SHALL register imem_rdata into if_inst and fetch_pc into if_pc, and SHALL set if_valid=1 from the next cycle (state HOLD).
REQ-017 In HOLD: if_valid, if_pc and if_inst SHALL remain stable until if_ready=1; on acceptance, fetch_pc <= if_pc+4 (modulo 2^32, wrapping from 32'hFFFF_FFFC to 0) -> REQ.
REQ-018 At most one request SHALL be outstanding; imem_req=0 in WAIT, HOLD and DROP.
REQ-019 redirect_valid SHALL take priority over every other event in the same cycle.
REQ-020 On redirect in REQ without gnt: fetch_pc <= redirect_pc, remain in REQ.
REQ-021 On redirect in REQ with gnt, or in WAIT without rvalid: fetch_pc <= redirect_pc -> DROP.
REQ-022 On redirect in WAIT with rvalid, or in HOLD (with or without if_ready): the response or held instruction SHALL be discarded; if_valid=0 the next cycle; fetch_pc <= redirect_pc -> REQ.
REQ-023 DROP: on imem_rvalid the data SHALL be discarded -> REQ; a further redirect in DROP SHALL only update fetch_pc.
REQ-024 if_valid SHALL be 1 only in HOLD.
REQ-025 Steady-state throughput SHALL be one instruction per 3 cycles with 1-cycle memory latency and if_ready=1.

Reset
REQ-026 While rst_n=0 at a clock edge: state <= REQ, fetch_pc <= RESET_PC, if_pc <= 0, if_inst <= 32'h0000_0013 (NOP); if_valid is 0 and imem_req is 0 during reset; all in-flight state is abandoned.
REQ-027 imem_req SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC; a response to a request issued before reset SHALL not occur (memory is reset together with the block).

Configuration
REQ-028 With macro PC_FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL drive output if_misalign (1 bit, reset 0) high and enter state TRAP (no requests, if_valid=0) until the next aligned redirect, which clears if_misalign and proceeds as REQ-020..REQ-023.
REQ-029 Without PC_FETCH_MISALIGN_TRAP_EN, the if_misalign port and the TRAP state SHALL not exist, and redirect_pc[1:0] SHALL be forced to 2'b00.

Verification
REQ-030 Reset release, gnt=1, rvalid 1 cycle later, if_ready=1 -> addresses 0x0, 0x4, 0x8 issued; if_pc matches each address; one instruction per 3 cycles.
REQ-031 Hold if_ready=0 for 5 cycles with an instruction presented -> if_valid, if_pc and if_inst stay stable; imem_req=0; the next address is issued only after acceptance.
REQ-032 Redirect to 0x100 while in WAIT -> the old response is dropped, if_valid never shows it, the next imem_addr=0x100.
REQ-033 Redirect to 0x200 in the same cycle as rvalid with if_ready=1 -> the data is discarded and the next request is at 0x200.
REQ-034 fetch_pc=0xFFFF_FFFC accepted -> the next imem_addr=0x0000_0000.
REQ-035 Redirect to 0x102: with the macro, if_misalign=1 and no requests until a redirect to 0x300; without the macro, imem_addr=0x100.
